// File: rtl/ook_pkg.sv
// Shared constants, state encoding and helpers for the OOK run decoder.
package ook_pkg;
    localparam int OOK_BIT_DIV   = 655;
    localparam int OOK_CHIP_BITS = 42;
    localparam int OOK_HOLD      = 4;
    localparam int OOK_IDLE_BITS = 1024;
    localparam int OOK_LEN_W     = 13;
    localparam int OOK_CHIPS_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } ook_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/ook_bit_sampler.sv
// Bit-timing recovery: mid-bit divider aligned on acquisition, one strobe per bit.
// OOK_MAJORITY_EN selects a 2-of-3 vote centred on mid-bit (strobe one clock later).
module ook_bit_sampler import ook_pkg::*; #(
    parameter int BIT_DIV = OOK_BIT_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    input  logic acq_i,
    output logic strobe_o,
    output logic bit_o
);
    localparam int DIV_W = $clog2(BIT_DIV);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BIT_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_FULL = DIV_W'(BIT_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    assign tick = !acq_i && (div_q == '0);

    // While acquiring, a rising din starts the first half-bit so strobes land mid-bit.
    always_comb begin
        div_d = div_q;
        if (acq_i) begin
            if (din_i) div_d = DIV_HALF;
        end else if (tick) begin
            div_d = DIV_FULL;
        end else begin
            div_d = div_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) div_q <= '0;
        else     div_q <= div_d;
    end

`ifdef OOK_MAJORITY_EN
    logic [1:0] hist_q;
    logic       stb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            stb_q  <= 1'b0;
        end else begin
            hist_q <= {hist_q[0], din_i};
            stb_q  <= tick;
        end
    end

    assign strobe_o = stb_q;
    assign bit_o    = maj3(hist_q[1], hist_q[0], din_i);
`else
    assign strobe_o = tick;
    assign bit_o    = din_i;
`endif
endmodule

// File: rtl/ook_run_decoder.sv
// Measures OOK mark/space runs in bits and rounded chips; one event per run via valid/ready.
// Build option OOK_MAJORITY_EN (in ook_bit_sampler) enables 2-of-3 mid-bit voting.
module ook_run_decoder import ook_pkg::*; #(
    parameter int BIT_DIV   = OOK_BIT_DIV,
    parameter int CHIP_BITS = OOK_CHIP_BITS,
    parameter int HOLD      = OOK_HOLD,
    parameter int IDLE_BITS = OOK_IDLE_BITS,
    parameter int LEN_W     = OOK_LEN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   din,
    input  logic                   ev_ready,
    output logic                   ev_valid,
    output logic                   ev_mark,
    output logic [LEN_W-1:0]       ev_len,
    output logic [OOK_CHIPS_W-1:0] ev_chips,
    output logic                   ev_last,
    output logic                   busy,
    output logic                   overflow
);
    localparam int ZC_W = $clog2(HOLD + 1);
    localparam int CM_W = $clog2(CHIP_BITS);
    localparam int CW   = OOK_CHIPS_W;
    localparam logic [LEN_W-1:0] LEN_MAX  = '1;
    localparam logic [LEN_W-1:0] LEN_HOLD = LEN_W'(HOLD);
    localparam logic [LEN_W-1:0] LEN_IDLE = LEN_W'(IDLE_BITS);
    localparam logic [ZC_W-1:0]  ZC_LAST  = ZC_W'(HOLD - 1);
    localparam logic [CM_W-1:0]  CM_TOP   = CM_W'(CHIP_BITS - 1);
    // Chip accumulator presets for run lengths 0, 1 and HOLD: (CHIP_BITS/2 + n) as quotient/remainder
    localparam logic [CM_W-1:0]  CM_ZERO  = CM_W'((CHIP_BITS / 2) % CHIP_BITS);
    localparam logic [CM_W-1:0]  CM_ONE   = CM_W'((CHIP_BITS / 2 + 1) % CHIP_BITS);
    localparam logic [CM_W-1:0]  CM_HOLD  = CM_W'((CHIP_BITS / 2 + HOLD) % CHIP_BITS);
    localparam logic [CW-1:0]    CH_ZERO  = CW'((CHIP_BITS / 2) / CHIP_BITS);
    localparam logic [CW-1:0]    CH_ONE   = CW'((CHIP_BITS / 2 + 1) / CHIP_BITS);
    localparam logic [CW-1:0]    CH_HOLD  = CW'((CHIP_BITS / 2 + HOLD) / CHIP_BITS);

    ook_state_e       state_q, state_d;
    logic [LEN_W-1:0] run_q, run_d, run_inc;
    logic [ZC_W-1:0]  zc_q, zc_d;
    logic [CM_W-1:0]  cm_q, cm_d, cm_inc;
    logic [CW-1:0]    ch_q, ch_d, ch_inc, mch_q, mch_d;
    logic             stb, smp;
    logic             emit, e_mark, e_last;
    logic [LEN_W-1:0] e_len;
    logic [CW-1:0]    e_chips;

    ook_bit_sampler #(.BIT_DIV(BIT_DIV)) u_sampler (
        .clk      (clk),
        .rst      (rst),
        .din_i    (din),
        .acq_i    (state_q == IDLE),
        .strobe_o (stb),
        .bit_o    (smp)
    );

    always_comb begin
        run_inc = run_q;
        cm_inc  = cm_q;
        ch_inc  = ch_q;
        if (run_q != LEN_MAX) begin
            run_inc = run_q + LEN_W'(1);
            if (cm_q == CM_TOP) begin
                cm_inc = '0;
                if (ch_q != '1) ch_inc = ch_q + CW'(1);
            end else begin
                cm_inc = cm_q + CM_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        zc_d    = zc_q;
        cm_d    = cm_q;
        ch_d    = ch_q;
        mch_d   = mch_q;
        emit    = 1'b0;
        e_mark  = 1'b0;
        e_last  = 1'b0;
        e_len   = '0;
        e_chips = '0;
        case (state_q)
            IDLE: begin
                if (din) begin
                    state_d = MARK;
                    run_d   = '0;
                    zc_d    = '0;
                    cm_d    = CM_ZERO;
                    ch_d    = CH_ZERO;
                    mch_d   = CH_ZERO;
                end
            end
            MARK: begin
                if (stb) begin
                    run_d = run_inc;
                    cm_d  = cm_inc;
                    ch_d  = ch_inc;
                    if (smp) begin
                        zc_d  = '0;
                        mch_d = ch_inc;
                    end else if (zc_q == ZC_LAST) begin
                        // Chip count was captured at the last 1, so trailing zeros do not round it up
                        emit    = 1'b1;
                        e_mark  = 1'b1;
                        e_len   = run_inc - LEN_HOLD;
                        e_chips = mch_q;
                        state_d = SPACE;
                        run_d   = LEN_HOLD;
                        cm_d    = CM_HOLD;
                        ch_d    = CH_HOLD;
                        zc_d    = '0;
                    end else begin
                        zc_d = zc_q + ZC_W'(1);
                    end
                end
            end
            SPACE: begin
                if (stb) begin
                    if (smp) begin
                        emit    = 1'b1;
                        e_len   = run_q;
                        e_chips = ch_q;
                        state_d = MARK;
                        run_d   = LEN_W'(1);
                        cm_d    = CM_ONE;
                        ch_d    = CH_ONE;
                        mch_d   = CH_ONE;
                        zc_d    = '0;
                    end else begin
                        run_d = run_inc;
                        cm_d  = cm_inc;
                        ch_d  = ch_inc;
                        if (run_inc == LEN_IDLE) begin
                            emit    = 1'b1;
                            e_last  = 1'b1;
                            e_len   = run_inc;
                            e_chips = ch_inc;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            run_q   <= '0;
            zc_q    <= '0;
            cm_q    <= '0;
            ch_q    <= '0;
            mch_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            zc_q    <= zc_d;
            cm_q    <= cm_d;
            ch_q    <= ch_d;
            mch_q   <= mch_d;
        end
    end

    // Single-entry event slot: a full slot that is not draining drops the newcomer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ev_valid <= 1'b0;
            ev_mark  <= 1'b0;
            ev_len   <= '0;
            ev_chips <= '0;
            ev_last  <= 1'b0;
            overflow <= 1'b0;
        end else if (emit && (!ev_valid || ev_ready)) begin
            ev_valid <= 1'b1;
            ev_mark  <= e_mark;
            ev_len   <= e_len;
            ev_chips <= e_chips;
            ev_last  <= e_last;
        end else begin
            if (emit)     overflow <= 1'b1;
            if (ev_ready) ev_valid <= 1'b0;
        end
    end

    assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_ook_run_decoder.sv
// Directed bench for ook_run_decoder: expected run events in a table, plus handshake/reset sequences.
module tb_ook_run_decoder;
    localparam int BD = 6;
    localparam int LW = 13;
    localparam int NEV = 15;

    logic          clk = 1'b0;
    logic          rst, din, ev_ready;
    logic          ev_valid, ev_mark, ev_last, busy, overflow;
    logic [LW-1:0] ev_len;
    logic [7:0]    ev_chips;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string name;
        bit    mark;
        int    len;
        int    chips;
        bit    last;
    } ev_rec_t;

    ev_rec_t cap_q[$];
    ev_rec_t tbl[NEV];

    always #5 clk = ~clk;

    ook_run_decoder #(.BIT_DIV(BD)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .ev_ready (ev_ready),
        .ev_valid (ev_valid),
        .ev_mark  (ev_mark),
        .ev_len   (ev_len),
        .ev_chips (ev_chips),
        .ev_last  (ev_last),
        .busy     (busy),
        .overflow (overflow)
    );

    // Record every transfer that the next rising edge will perform
    always @(negedge clk) begin
        ev_rec_t r;
        if (!rst && ev_valid && ev_ready) begin
            r.name  = "";
            r.mark  = ev_mark;
            r.len   = int'(ev_len);
            r.chips = int'(ev_chips);
            r.last  = ev_last;
            cap_q.push_back(r);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_ev(input int i, input string nm, input bit m, input int l, input int c, input bit la);
        tbl[i].name  = nm;
        tbl[i].mark  = m;
        tbl[i].len   = l;
        tbl[i].chips = c;
        tbl[i].last  = la;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b);
        din = b;
        repeat (BD) tick();
    endtask

    task automatic send_pat(input string s);
        for (int i = 0; i < s.len(); i++) send_bit(s.getc(i) == "1");
    endtask

    task automatic zeros(input int n);
        repeat (n) send_bit(1'b0);
    endtask

    task automatic send_tone();
        repeat (10) send_pat("1000");
        send_pat("10");
    endtask

    // A 1 bit with a single-clock dip exactly at the mid-bit sample clock
    task automatic send_glitch();
        din = 1'b1;
        repeat (BD / 2) tick();
        din = 1'b0;
        tick();
        din = 1'b1;
        repeat (BD - BD / 2 - 1) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ev_valid"}, int'(ev_valid), 0);
        chk({tag, ".ev_mark"},  int'(ev_mark), 0);
        chk({tag, ".ev_len"},   int'(ev_len), 0);
        chk({tag, ".ev_chips"}, int'(ev_chips), 0);
        chk({tag, ".ev_last"},  int'(ev_last), 0);
        chk({tag, ".busy"},     int'(busy), 0);
        chk({tag, ".overflow"}, int'(overflow), 0);
    endtask

    initial begin
        int n0;
        set_ev(0,  "tdt_mark1",   1, 41,   1,  0);
        set_ev(1,  "tdt_space",   0, 43,   1,  0);
        set_ev(2,  "tdt_mark2",   1, 41,   1,  0);
        set_ev(3,  "tdt_idle",    0, 1024, 24, 1);
        set_ev(4,  "pre_mark",    1, 681,  16, 0);
        set_ev(5,  "pre_space",   0, 345,  8,  0);
        set_ev(6,  "pre_tone",    1, 41,   1,  0);
        set_ev(7,  "pre_idle",    0, 1024, 24, 1);
        set_ev(8,  "bp_held",     1, 41,   1,  0);
        set_ev(9,  "bp_mark1",    1, 1,    0,  0);
        set_ev(10, "bp_idle",     0, 1024, 24, 1);
        set_ev(11, "rst_tone",    1, 41,   1,  0);
        set_ev(12, "rst_idle",    0, 1024, 24, 1);
        set_ev(13, "glitch_mark", 1, 21,   1,  0);
        set_ev(14, "glitch_idle", 0, 1024, 24, 1);

        rst = 1'b1;
        din = 1'b0;
        ev_ready = 1'b1;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Tone, gap, tone, then silence to end of message
        send_tone();
        chk("busy_in_mark", int'(busy), 1);
        zeros(42);
        send_tone();
        zeros(1026);
        chk("busy_after_idle", int'(busy), 0);

        // Long preamble reacquired from IDLE
        repeat (171) send_pat("1000");
        zeros(342);
        send_tone();
        zeros(1026);

        // Backpressure: mark held, following space dropped
        ev_ready = 1'b0;
        send_tone();
        zeros(42);
        send_bit(1'b1);
        chk("bp.ev_valid", int'(ev_valid), 1);
        chk("bp.ev_mark",  int'(ev_mark), 1);
        chk("bp.ev_len",   int'(ev_len), 41);
        chk("bp.ev_chips", int'(ev_chips), 1);
        chk("bp.ev_last",  int'(ev_last), 0);
        chk("bp.overflow", int'(overflow), 1);
        n0 = cap_q.size();
        ev_ready = 1'b1;
        send_bit(1'b0);
        chk("bp.transfers", cap_q.size() - n0, 1);
        chk("bp.valid_after", int'(ev_valid), 0);
        chk("bp.overflow_sticky", int'(overflow), 1);
        zeros(1025);

        // Reset pulse mid-mark discards the partial run
        send_pat("10001000");
        n0 = cap_q.size();
        rst = 1'b1;
        tick();
        chk_all_zero("midrst");
        rst = 1'b0;
        chk("midrst.no_event", cap_q.size() - n0, 0);
        send_tone();
        zeros(1026);

        // Single-clock dip inside a solid mark
        repeat (10) send_bit(1'b1);
        send_glitch();
        repeat (10) send_bit(1'b1);
        zeros(1026);

        chk("event_count", cap_q.size(), NEV);
        for (int i = 0; i < NEV; i++) begin
            if (i < cap_q.size()) begin
                chk({tbl[i].name, ".mark"},  int'(cap_q[i].mark), int'(tbl[i].mark));
                chk({tbl[i].name, ".len"},   cap_q[i].len, tbl[i].len);
                chk({tbl[i].name, ".chips"}, cap_q[i].chips, tbl[i].chips);
                chk({tbl[i].name, ".last"},  int'(cap_q[i].last), int'(tbl[i].last));
            end else begin
                checks++;
                failures++;
                $display("FAIL %s: got no event expected len %0d", tbl[i].name, tbl[i].len);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
